// File: rtl/priority_encoder_8to3_if.sv
// Request/result bundle for the 8-to-3 priority encoder.
// The requester drives D and consumes the registered index B and its
// qualifying valid flag; the encoder does the opposite.
interface priority_encoder_8to3_if;
    logic [7:0] D;
    logic [2:0] B;
    logic       valid;

    modport master (
        output D,
        input  B,
        input  valid
    );

    modport slave (
        input  D,
        output B,
        output valid
    );
endinterface

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder.
// Bit 7 of D has the highest priority. The index of the highest asserted
// bit and an any-bit-set flag are registered every cycle (one clock of
// latency, no enable). D = 8'h00 and D = 8'h01 both encode to 3'b000, so
// consumers must qualify B with valid.
module priority_encoder_8to3 (
    input  logic                    clk,
    input  logic                    rst_n,
    priority_encoder_8to3_if.slave  bus
);

    logic [2:0] index_s;
    logic       any_s;
    logic [2:0] b_r;
    logic       valid_r;

    // Leading-one position with bits below the leading one treated as don't-care.
    function automatic logic [2:0] encode_index(input logic [7:0] d);
        logic [2:0] idx;
        casez (d)
            8'b1???_????: idx = 3'd7;
            8'b01??_????: idx = 3'd6;
            8'b001?_????: idx = 3'd5;
            8'b0001_????: idx = 3'd4;
            8'b0000_1???: idx = 3'd3;
            8'b0000_01??: idx = 3'd2;
            8'b0000_001?: idx = 3'd1;
            8'b0000_0001: idx = 3'd0;
            default:      idx = 3'd0;
        endcase
        return idx;
    endfunction

    // Combinational encode of the current request vector.
    always_comb begin
        index_s = 3'd0;
        any_s   = 1'b0;
        index_s = encode_index(bus.D);
        any_s   = |bus.D;
    end

    // Result registers; reset clears them immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_r     <= 3'd0;
            valid_r <= 1'b0;
        end else begin
            b_r     <= index_s;
            valid_r <= any_s;
        end
    end

    assign bus.B     = b_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Self-checking bench for priority_encoder_8to3: a behavioural model
// (leading-one position from floor(log2(D))) predicts the registered
// outputs, a compare process checks them every falling clock edge, and
// directed sequences add hand-computed literal expectations.
module tb_priority_encoder_8to3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   cmp_en;
    int   exp_b;
    int   exp_v;

    priority_encoder_8to3_if bus ();

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Highest set bit index: floor(log2(d)) for d > 0, zero for d == 0.
    function automatic int model_idx(input int d);
        if (d == 0) return 0;
        return $clog2(d + 1) - 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference registers: same observable behaviour as the spec, from the model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_b <= 0;
            exp_v <= 0;
        end else begin
            exp_b <= model_idx(int'(bus.D));
            exp_v <= (bus.D != 8'h00) ? 1 : 0;
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("B_vs_model", int'(bus.B), exp_b);
            chk("valid_vs_model", int'(bus.valid), exp_v);
        end
    end

    task automatic set_d(input logic [7:0] d);
        @(posedge clk);
        #2 bus.D = d;
    endtask

    // Drive a sequence back to back and check each result one cycle later.
    task automatic run_seq(input logic [7:0] ds[4], input int eb[4], input int ev[4],
                           input string name);
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk({name, "_B"}, int'(bus.B), eb[i-1]);
                chk({name, "_valid"}, int'(bus.valid), ev[i-1]);
            end
            #1;
            if (i < 4) bus.D = ds[i];
        end
    endtask

    initial begin
        logic [7:0] s_d[4];
        int         s_b[4];
        int         s_v[4];
        int         v;

        n_cmp  = 0;
        n_bad  = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b1;
        bus.D  = 8'hFF;

        // Pin the model with hand-computed positions.
        v = 8'h05; chk("model_05", model_idx(v), 2);
        v = 8'h0C; chk("model_0C", model_idx(v), 3);
        v = 8'h1F; chk("model_1F", model_idx(v), 4);
        v = 8'h3A; chk("model_3A", model_idx(v), 5);
        v = 8'h80; chk("model_80", model_idx(v), 7);
        v = 8'h01; chk("model_01", model_idx(v), 0);

        // Reset held with D all ones while the clock runs.
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_B", int'(bus.B), 0);
        chk("reset_valid", int'(bus.valid), 0);

        // Release with D = 8'h10 stable: first edge samples normally.
        bus.D = 8'h10;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_B", int'(bus.B), 4);
        chk("release_valid", int'(bus.valid), 1);

        // Zero versus bit 0.
        s_d = '{8'h00, 8'h01, 8'h00, 8'h01};
        s_b = '{0, 0, 0, 0};
        s_v = '{0, 1, 0, 1};
        run_seq(s_d, s_b, s_v, "zero_vs_bit0");

        // Priority masking.
        s_d = '{8'b1000_0001, 8'b0111_1111, 8'b0010_0000, 8'b0000_0110};
        s_b = '{7, 6, 5, 2};
        s_v = '{1, 1, 1, 1};
        run_seq(s_d, s_b, s_v, "masking");

        // Back-to-back pipelining.
        s_d = '{8'h80, 8'h08, 8'h00, 8'h03};
        s_b = '{7, 3, 0, 1};
        s_v = '{1, 1, 0, 1};
        run_seq(s_d, s_b, s_v, "pipeline");

        // Exhaustive sweep.
        for (int i = 0; i < 256; i++) set_d(8'(i));

        // Randomized stimulus.
        for (int i = 0; i < 400; i++) set_d(8'($urandom_range(0, 255)));

        // Asynchronous reset mid-cycle while B = 7.
        set_d(8'hFF);
        @(posedge clk);
        #1 chk("pre_async_B", int'(bus.B), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_B", int'(bus.B), 0);
        chk("async_valid", int'(bus.valid), 0);
        repeat (2) @(posedge clk);
        #1 chk("held_reset_B", int'(bus.B), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) set_d(8'($urandom));
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
